// File: rtl/tile_pkg.sv
// Shared types and geometry for the tile-state RAM and its arbiter.
// The grant encoding is common to the arbiter and anything that decodes rsp_sel.
package tile_pkg;

  localparam int TILE_COLS  = 32;
  localparam int TILE_ROWS  = 24;
  localparam int TILE_PX    = 20;
  localparam int TILE_COUNT = TILE_COLS * TILE_ROWS;
  localparam int ADDR_W     = 10;
  localparam int DATA_W     = 16;

  typedef enum logic [1:0] {
    G_NONE = 2'd0,
    G_DISP = 2'd1,
    G_GRD  = 2'd2,
    G_GWR  = 2'd3
  } grant_t;

  // Row-major tile index; rows are TILE_COLS words apart in the RAM.
  function automatic logic [ADDR_W-1:0] tile_addr(input logic [4:0] col,
                                                  input logic [4:0] row);
    return ADDR_W'(int'(row) * TILE_COLS + int'(col));
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO used as the game write queue.
// The head entry is presented combinationally on o_rdata; callers guard push/pop.
module sync_fifo #(
  parameter int WIDTH = 26,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [WIDTH-1:0]         i_wdata,
  output logic [WIDTH-1:0]         o_rdata,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;

  // NOTE: the storage array is deliberately left out of reset; only the
  // pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      unique case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_full  = (r_count == (PTR_W+1)'(DEPTH));
  assign o_empty = (r_count == '0);

endmodule

// File: rtl/tile_mem_arbiter.sv
// Single-port tile RAM arbiter: display reads win, game writes queue and drain
// on free cycles, game reads wait for the queue to empty (read-after-write).
module tile_mem_arbiter #(
  parameter int ADDR_W     = tile_pkg::ADDR_W,
  parameter int DATA_W     = tile_pkg::DATA_W,
  parameter int WQ_DEPTH   = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_valid,
  output logic [DATA_W-1:0] disp_data,
  input  logic              game_rd_valid,
  output logic              game_rd_ready,
  input  logic [ADDR_W-1:0] game_rd_addr,
  output logic              game_rd_rvalid,
  output logic [DATA_W-1:0] game_rd_rdata,
  input  logic              game_wr_valid,
  output logic              game_wr_ready,
  input  logic [ADDR_W-1:0] game_wr_addr,
  input  logic [DATA_W-1:0] game_wr_data,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              wq_starved
);

  import tile_pkg::*;

  localparam int CNT_W = $clog2(WQ_DEPTH) + 1;
  localparam int STV_W = $clog2(STARVE_MAX + 1);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wq_entry_t;

  wq_entry_t        w_wq_in;
  wq_entry_t        w_wq_head;
  logic [CNT_W-1:0] w_wq_count;
  logic             w_wq_full;
  logic             w_wq_empty;
  logic             w_push;
  logic             w_pop;
  grant_t           w_grant;
  logic [STV_W-1:0] w_starve_nxt;

  grant_t           r_rsp_sel;
  logic [STV_W-1:0] r_starve_cnt;
  logic             r_wq_starved;

  assign game_wr_ready = !reset && (w_wq_count < CNT_W'(WQ_DEPTH));
  assign game_rd_ready = !reset && !disp_req && w_wq_empty;

  assign w_wq_in = '{addr: game_wr_addr, data: game_wr_data};
  assign w_push  = game_wr_valid && game_wr_ready && !w_wq_full;
  assign w_pop   = (w_grant == G_GWR);

  sync_fifo #(
    .WIDTH (ADDR_W + DATA_W),
    .DEPTH (WQ_DEPTH)
  ) u_wq (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata (w_wq_in),
    .o_rdata (w_wq_head),
    .o_count (w_wq_count),
    .o_full  (w_wq_full),
    .o_empty (w_wq_empty)
  );

  // NOTE: every combinational output gets a default first, so no path
  // through the block can leave a value unassigned and infer a latch.
  always_comb begin
    w_grant = G_NONE;
    if (!reset) begin
      if (disp_req)           w_grant = G_DISP;
      else if (!w_wq_empty)   w_grant = G_GWR;
      else if (game_rd_valid) w_grant = G_GRD;
    end
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (w_grant)
      G_DISP: begin
        mem_en   = 1'b1;
        mem_addr = disp_addr;
      end
      G_GWR: begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = w_wq_head.addr;
        mem_wdata = w_wq_head.data;
      end
      G_GRD: begin
        mem_en   = 1'b1;
        mem_addr = game_rd_addr;
      end
      default: ;
    endcase
  end

  // Starvation only counts display-won cycles while writes are waiting.
  always_comb begin
    w_starve_nxt = r_starve_cnt;
    if (w_wq_empty || w_grant == G_GWR)
      w_starve_nxt = '0;
    else if (w_grant == G_DISP && r_starve_cnt != STV_W'(STARVE_MAX))
      w_starve_nxt = r_starve_cnt + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rsp_sel    <= G_NONE;
      r_starve_cnt <= '0;
      r_wq_starved <= 1'b0;
    end else begin
      r_rsp_sel    <= (w_grant == G_GWR) ? G_NONE : w_grant;
      r_starve_cnt <= w_starve_nxt;
      if (w_starve_nxt == STV_W'(STARVE_MAX)) r_wq_starved <= 1'b1;
    end
  end

  assign disp_valid     = (r_rsp_sel == G_DISP);
  assign game_rd_rvalid = (r_rsp_sel == G_GRD);
  assign disp_data      = mem_rdata;
  assign game_rd_rdata  = mem_rdata;
  assign wq_starved     = r_wq_starved;

endmodule

// File: doc/tile_mem_arbiter.md
# tile_mem_arbiter

Shares the single-port tile-state RAM (one 16-bit word per 20x20 tile, 32x24 grid) between two requesters. The display fetch path reads the word that feeds the pixel-pattern FSM. The game logic reads and writes snake/food state. Display reads always win; game writes are buffered in a small FIFO and drained on free cycles. The block sits between the game core, the VGA pixel pipeline and the RAM.

## Interface
Parameters:
- ADDR_W, 10, tile RAM address width (768 of 1024 words used)
- DATA_W, 16, tile state word width
- WQ_DEPTH, 4, write-queue entries (power of two)
- STARVE_MAX, 8, consecutive display-occupied cycles with a non-empty queue before the starve flag sets

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- disp_req  in  1  display read request; serviced in the same cycle
- disp_addr  in  ADDR_W  display read address
- disp_valid  out  1  disp_data valid
- disp_data  out  DATA_W  display read data
- game_rd_valid  in  1  game read request
- game_rd_ready  out  1  game read accepted when valid & ready
- game_rd_addr  in  ADDR_W  game read address
- game_rd_rvalid  out  1  game read data valid
- game_rd_rdata  out  DATA_W  game read data
- game_wr_valid  in  1  game write request
- game_wr_ready  out  1  write accepted into queue when valid & ready
- game_wr_addr  in  ADDR_W  write address
- game_wr_data  in  DATA_W  write data
- mem_en, mem_we  out  1  RAM enable / write enable
- mem_addr  out  ADDR_W  RAM address
- mem_wdata  out  DATA_W  RAM write data
- mem_rdata  in  DATA_W  RAM read data; 1-cycle latency after mem_en & !mem_we
- wq_starved  out  1  sticky: queue starved by display for STARVE_MAX cycles

## Operation
- Per-cycle grant, fixed priority:
  - Display (disp_req).
  - Write-queue head (queue non-empty).
  - Game read (game_rd_valid & queue empty).
- Grant encoding:
  - G_DISP: mem_en=1, mem_we=0, mem_addr=disp_addr.
  - G_GWR: mem_en=1, mem_we=1, mem_addr/mem_wdata = queue head; pop.
  - G_GRD: mem_en=1, mem_we=0, mem_addr=game_rd_addr.
  - G_NONE: mem_en=0; mem_addr and mem_wdata are held at 0.
- game_rd_ready = !reset & !disp_req & queue empty. Reads wait until all earlier accepted writes have drained, so read-after-write ordering holds.
- game_wr_ready = !reset & (count < WQ_DEPTH). There is no pass-through when the queue is full, even if it pops in the same cycle. An accepted write reaches the RAM no earlier than the next cycle.
- Push and pop in the same cycle: count is unchanged and FIFO order is kept.
- Display reads are not ordered against queued writes. A display read may return pre-write data; a tile updating mid-frame is accepted.
- Read response routing: the registered grant (rsp_sel) picks disp_valid or game_rd_rvalid in the cycle after the grant. disp_data and game_rd_rdata both carry mem_rdata.
- Starve counter:
  - Increments each cycle with queue non-empty & G_DISP.
  - Clears on any G_GWR or when the queue is empty.
  - Saturates at STARVE_MAX and then sets wq_starved. Only reset clears wq_starved.

## Timing
- Reset (asynchronous): queue empty, rsp_sel=G_NONE, starve count 0, wq_starved=0, disp_valid=0, game_rd_rvalid=0. Ready outputs are 0 while reset is high.
- disp_req high in cycle N: disp_valid=1 with data in N+1. Back-to-back requests give back-to-back valids.
- Game read accepted in N: game_rd_rvalid in N+1.
- Write accepted in N with the queue empty and no disp_req in N+1: mem_we=1 in N+1.
- Reset asserted mid-operation: queued writes are discarded and in-flight read responses are suppressed (no valid in the following cycle).

## Structure
- Package tile_pkg: TILE_COLS=32, TILE_ROWS=24, TILE_PX=20, ADDR_W, DATA_W, enum grant_t {G_NONE, G_DISP, G_GRD, G_GWR}.
- Sub-module sync_fifo: WQ_DEPTH entries of {addr, data}, with count, full and empty outputs and an asynchronous reset.
- Top level holds the grant mux, the rsp_sel register and the starve counter.

## Test plan
- disp_req every cycle for 10 cycles, addr 0..9, mem model returns addr+16'h100:
  - disp_valid in cycles 1..10 with data 16'h100..16'h109.
  - game_rd_ready stays 0 throughout.
- 4 writes in 4 cycles while disp_req held high:
  - game_wr_ready drops after the 4th write.
  - With STARVE_MAX=8, wq_starved sets after 8 cycles.
  - Release disp_req: writes drain in order, one per cycle.
- Write addr 5 = 16'hBEEF, then an immediate game read of addr 5:
  - Read is held (ready=0) until the write issues.
  - game_rd_rvalid returns 16'hBEEF.
- Queue full, then push and pop in the same cycle:
  - The push is refused because ready=0.
  - Next cycle ready=1 and count=3.
- Reset asserted for 1 cycle with 3 writes queued and a game read outstanding:
  - No mem_we afterwards.
  - No rvalid pulse.
  - wq_starved=0.
- Idle (no requests): mem_en=0 and all valids 0 for 20 cycles.
